// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle unsigned multiply / divide engine for the EX stage. An
//   accepted operation runs WIDTH iterations of a shift-add multiplier or a
//   restoring divider while holding the pipeline, then presents the result
//   with a one-cycle done pulse.
//
// Handshake: i_start is a request that is only honoured in IDLE with a
//   multiply (4'b0010) or divide (4'b0011) control code; there is no ready
//   signal, the caller holds the pipe while o_stall is high and captures
//   o_op1/o_r15 in the cycle o_done is high.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), synchronous active-low reset
//   i_start, i_control  request and ALU control code
//   i_a, i_b            multiplicand/dividend, multiplier/divisor
//   o_stall             combinational pipeline hold
//   o_busy              registered "operation in progress"
//   o_done              one-cycle result-valid pulse
//   o_op1, o_r15        product low/high or quotient/remainder
//   o_div_by_zero       divide with zero divisor, set with done
//   o_dbg_state         FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, an accepted operation with a zero operand bypasses RUN and
//   completes in the next cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_control,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_op1,
  output logic [WIDTH-1:0] o_r15,
  output logic             o_div_by_zero,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]       CTRL_MUL = 4'b0010;
  localparam logic [3:0]       CTRL_DIV = 4'b0011;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_opnd;     // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0]   r_a;        // dividend copy for the divide-by-zero result
  logic [2*WIDTH-1:0] r_acc;      // {hi, lo} for mul, {rem, quot} for div
  logic               r_busy;
  logic [WIDTH-1:0]   r_op1, r_r15;
  logic               r_dz;

  logic               w_valid_ctrl, w_accept, w_last, w_early;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_ok;

  assign w_valid_ctrl = (i_control == CTRL_MUL) || (i_control == CTRL_DIV);
  assign w_accept     = (r_state == S_IDLE) && i_start && w_valid_ctrl;
  assign w_last       = (r_state == S_RUN) && (r_cnt == LAST_CNT);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = w_accept && ((i_a == '0) || (i_b == '0));
`else
  assign w_early = 1'b0;
`endif

  // Multiply step: conditional add into the upper half with carry, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: shift {rem,quot} left, trial subtract. The shifted remainder
  // needs WIDTH+1 bits; the extra top bit of the difference is the borrow.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = {1'b0, w_rem_sh} - {2'b00, r_opnd};
  assign w_div_ok   = ~w_div_diff[WIDTH+1];
  assign w_div_next = w_div_ok ? {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                               : {w_rem_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0};

  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_early ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_opnd   <= '0;
      r_a      <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_op1    <= '0;
      r_r15    <= '0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= (i_control == CTRL_DIV);
      r_opnd   <= (i_control == CTRL_DIV) ? i_b : i_a;
      r_a      <= i_a;
      // Low half starts as the multiplier (mul) or the dividend (div).
      r_acc    <= {{WIDTH{1'b0}}, (i_control == CTRL_DIV) ? i_a : i_b};
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      r_busy   <= ~w_early;
`ifdef MULDIV_EARLY_OUT_EN
      if (w_early) begin
        if ((i_control == CTRL_DIV) && (i_b == '0)) begin
          r_op1 <= '1;
          r_r15 <= i_a;
          r_dz  <= 1'b1;
        end else begin
          r_op1 <= '0;
          r_r15 <= '0;
        end
      end
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
        if (r_is_div && (r_opnd == '0)) begin
          r_op1 <= '1;
          r_r15 <= r_a;
          r_dz  <= 1'b1;
        end else begin
          r_op1 <= w_acc_next[WIDTH-1:0];
          r_r15 <= w_acc_next[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign o_stall       = r_busy | w_accept;
  assign o_busy        = r_busy;
  assign o_done        = (r_state == S_DONE);
  assign o_op1         = r_op1;
  assign o_r15         = r_r15;
  assign o_div_by_zero = r_dz;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=16).
module tb_muldiv_sequencer;

  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] DIV = 4'b0011;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  control;
  logic [15:0] a, b;
  logic        stall, busy, done, dz;
  logic [15:0] op1, r15;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_op1 = 16'h0000;
  logic [15:0] last_r15 = 16'h0000;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_control(control),
    .i_a(a), .i_b(b), .o_stall(stall), .o_busy(busy), .o_done(done),
    .o_op1(op1), .o_r15(r15), .o_div_by_zero(dz), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation at a negedge, then follow it to the done pulse.
  // pulse_at > 0 raises a competing start for one cycle at that count.
  task automatic run_op(input string name, input logic [3:0] ctrl,
                        input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] e_op1, input logic [15:0] e_r15,
                        input logic e_dz, input int e_lat, input int pulse_at);
    int cyc;
    int stall_low;
    @(negedge clk);
    start = 1'b1; control = ctrl; a = va; b = vb;
    #1 check({name, ".stall_accept"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    stall_low = 0;
    if (e_lat > 1) begin
      check({name, ".busy_run"},  32'(busy),      32'd1);
      check({name, ".state_run"}, 32'(dbg_state), 32'd1);
      check({name, ".dz_clear"},  32'(dz),        32'd0);
      check({name, ".op1_hold"},  32'(op1),       32'(last_op1));
      check({name, ".r15_hold"},  32'(r15),       32'(last_r15));
    end
    while (!done && cyc < 40) begin
      if (!stall) stall_low++;
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == pulse_at) begin
        control = DIV; a = 16'hFFFF; b = 16'h0001;
      end
    end
    start = 1'b0;
    check({name, ".latency"},   32'(cyc),       32'(e_lat));
    check({name, ".stall_run"}, 32'(stall_low), 32'd0);
    check({name, ".done"},      32'(done),      32'd1);
    check({name, ".stall_done"},32'(stall),     32'd0);
    check({name, ".busy_done"}, 32'(busy),      32'd0);
    check({name, ".state_done"},32'(dbg_state), 32'd2);
    check({name, ".op1"},       32'(op1),       32'(e_op1));
    check({name, ".r15"},       32'(r15),       32'(e_r15));
    check({name, ".dz"},        32'(dz),        32'(e_dz));
    last_op1 = e_op1;
    last_r15 = e_r15;
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(done),      32'd0);
    check({name, ".state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; control = 4'h0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.done",  32'(done),      32'd0);
    check("rst.stall", 32'(stall),     32'd0);
    check("rst.op1",   32'(op1),       32'd0);
    check("rst.r15",   32'(r15),       32'd0);
    check("rst.dz",    32'(dz),        32'd0);
    check("rst.state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    run_op("mul_ff_101",  MUL, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 17, 0);
    run_op("mul_max",     MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17, 0);
    run_op("div_1000_7",  DIV, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 17, 0);
    run_op("div_by_zero", DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, DZ_LAT, 0);

    // Unsupported control code: no acceptance, outputs untouched.
    @(negedge clk);
    start = 1'b1; control = 4'b0000; a = 16'h0007; b = 16'h0003;
    #1 check("bad_ctrl.stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("bad_ctrl.busy",  32'(busy),      32'd0);
    check("bad_ctrl.state", 32'(dbg_state), 32'd0);
    check("bad_ctrl.op1",   32'(op1),       32'h0000FFFF);
    check("bad_ctrl.r15",   32'(r15),       32'h00001234);
    check("bad_ctrl.dz",    32'(dz),        32'd1);

    // Competing start mid-RUN is ignored; also clears the sticky dz flag.
    run_op("mul_pulse", MUL, 16'h0010, 16'h0020, 16'h0200, 16'h0000, 1'b0, 17, 6);
    run_op("div_exact", DIV, 16'd50000, 16'd250, 16'd200, 16'd0, 1'b0, 17, 0);

    // Reset at RUN cycle 8 aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; control = MUL; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort.state_before", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.state", 32'(dbg_state), 32'd0);
    check("abort.busy",  32'(busy),      32'd0);
    check("abort.done",  32'(done),      32'd0);
    check("abort.op1",   32'(op1),       32'd0);
    check("abort.r15",   32'(r15),       32'd0);
    check("abort.dz",    32'(dz),        32'd0);
    check("abort.stall", 32'(stall),     32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    last_op1 = 16'h0000;
    last_r15 = 16'h0000;

    run_op("mul_3_5", MUL, 16'd3, 16'd5, 16'd15, 16'd0, 1'b0, 17, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
